// File: rtl/radiant_trig_sched.sv
// -----------------------------------------------------------------------------
// radiant_trig_sched
//
// Trigger scheduler sitting upstream of the event control core. It accepts raw
// trigger pulses and allocates a free digitizer buffer round-robin. It then
// issues a one-cycle event strobe and waits for digitization to finish. After
// that it enforces a programmable holdoff. Buffers only return to the free pool
// when readout releases them. Triggers that cannot be served are flagged dead.
//
// Optional build macro:
//   RADIANT_TRIG_DEADCOUNT_EN - when defined, dead_count_o is a saturating
//                               32-bit tally of dead_trig_o pulses; when
//                               undefined it is tied to zero.
//
// Ports:
//   clk_i            system clock (only clock of this block)
//   rst_i            synchronous active-high reset
//   run_en_i         trigger enable; triggers ignored (not dead) when low
//   trig_i           one-cycle trigger request
//   trig_type_i      trigger type, sampled with trig_i
//   holdoff_i        holdoff length in cycles, sampled when DIGITIZE ends
//   event_o          one-cycle strobe: trigger accepted
//   event_type_o     type of the accepted trigger
//   event_buf_o      allocated buffer index, held until the next event_o
//   dig_done_i       digitization complete pulse
//   event_done_o     one-cycle pulse after an accepted dig_done_i
//   event_done_buf_o buffer that just completed digitization
//   release_i        readout finished with a buffer
//   release_buf_i    index of the buffer being released
//   busy_o           scheduler is not idle
//   free_count_o     number of free buffers
//   dead_trig_o      one-cycle pulse: trigger rejected
//   dead_count_o     dead-trigger count (zero when the counter is not built)
// -----------------------------------------------------------------------------
module radiant_trig_sched #(
    parameter int NUM_BUFS = 4,
    parameter int BUF_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_en_i,
    input  logic                trig_i,
    input  logic                trig_type_i,
    input  logic [15:0]         holdoff_i,
    output logic                event_o,
    output logic                event_type_o,
    output logic [BUF_BITS-1:0] event_buf_o,
    input  logic                dig_done_i,
    output logic                event_done_o,
    output logic [BUF_BITS-1:0] event_done_buf_o,
    input  logic                release_i,
    input  logic [BUF_BITS-1:0] release_buf_i,
    output logic                busy_o,
    output logic [BUF_BITS:0]   free_count_o,
    output logic                dead_trig_o,
    output logic [31:0]         dead_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIGITIZE = 2'd1,
        ST_HOLDOFF  = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUM_BUFS-1:0] free_q;
    logic [NUM_BUFS-1:0] free_d;
    logic [NUM_BUFS-1:0] alloc_mask;
    logic [NUM_BUFS-1:0] rel_mask;
    logic [BUF_BITS-1:0] ptr_q;
    logic [BUF_BITS-1:0] cur_buf_q;
    logic [15:0]         hold_cnt_q;
    logic [BUF_BITS:0]   free_cnt_d;
    logic [BUF_BITS:0]   free_count_q;

    logic                event_q;
    logic                event_type_q;
    logic [BUF_BITS-1:0] event_buf_q;
    logic                event_done_q;
    logic [BUF_BITS-1:0] event_done_buf_q;
    logic                dead_q;

    logic                trig_req;
    logic                accept;
    logic                dead;
    logic                alloc_found;
    logic [BUF_BITS-1:0] alloc_idx;
    logic [BUF_BITS-1:0] cand;
    logic                rel_in_range;
    logic                rel_ok;

    // (base + off) mod NUM_BUFS; works for non power-of-two buffer counts.
    // Both operands are below NUM_BUFS, so a single conditional subtract is enough.
    function automatic logic [BUF_BITS-1:0] wrap_add(
        input logic [BUF_BITS-1:0] base,
        input logic [BUF_BITS:0]   off
    );
        logic [BUF_BITS:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= (BUF_BITS+1)'(NUM_BUFS)) begin
            sum = sum - (BUF_BITS+1)'(NUM_BUFS);
        end
        return sum[BUF_BITS-1:0];
    endfunction

    assign trig_req = trig_i & run_en_i;

    // First free buffer at or after the round-robin pointer, with wrap.
    // The search uses the pre-edge free mask, so a same-cycle release cannot feed it.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            cand = wrap_add(ptr_q, (BUF_BITS+1)'(i));
            if (!alloc_found && free_q[cand]) begin
                alloc_found = 1'b1;
                alloc_idx   = cand;
            end
        end
    end

    assign accept = trig_req && (state_q == ST_IDLE) && alloc_found;
    assign dead   = trig_req && !accept;

    // A release is ignored in three cases: the index is out of range, the
    // buffer is already free, or the buffer is the one being digitized.
    assign rel_in_range = ({1'b0, release_buf_i} < (BUF_BITS+1)'(NUM_BUFS));
    assign rel_ok = release_i && rel_in_range && !free_q[release_buf_i]
                    && !((state_q == ST_DIGITIZE) && (release_buf_i == cur_buf_q));

    for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_buf
        assign alloc_mask[gi] = accept && (alloc_idx == BUF_BITS'(gi));
        assign rel_mask[gi]   = rel_ok && (release_buf_i == BUF_BITS'(gi));
        assign free_d[gi]     = (free_q[gi] & ~alloc_mask[gi]) | rel_mask[gi];
    end

    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            free_cnt_d = free_cnt_d + {{BUF_BITS{1'b0}}, free_d[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            free_q           <= '1;
            free_count_q     <= (BUF_BITS+1)'(NUM_BUFS);
            ptr_q            <= '0;
            cur_buf_q        <= '0;
            hold_cnt_q       <= '0;
            event_q          <= 1'b0;
            event_type_q     <= 1'b0;
            event_buf_q      <= '0;
            event_done_q     <= 1'b0;
            event_done_buf_q <= '0;
            dead_q           <= 1'b0;
        end else begin
            event_q      <= 1'b0;
            event_done_q <= 1'b0;
            dead_q       <= dead;
            free_q       <= free_d;
            free_count_q <= free_cnt_d;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        event_q      <= 1'b1;
                        event_buf_q  <= alloc_idx;
                        event_type_q <= trig_type_i;
                        cur_buf_q    <= alloc_idx;
                        ptr_q        <= wrap_add(alloc_idx, (BUF_BITS+1)'(1));
                        state_q      <= ST_DIGITIZE;
                    end
                end
                ST_DIGITIZE: begin
                    if (dig_done_i) begin
                        event_done_q     <= 1'b1;
                        event_done_buf_q <= cur_buf_q;
                        if (holdoff_i == 16'd0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            hold_cnt_q <= holdoff_i;
                            state_q    <= ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // The event_done cycle is the first holdoff cycle, so we
                    // leave on count 1 to make holdoff_i cycles in total.
                    if (hold_cnt_q <= 16'd1) begin
                        hold_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef RADIANT_TRIG_DEADCOUNT_EN
    logic [31:0] dead_count_q;

    // Counts in step with dead_q so the count already includes the visible pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dead_count_q <= '0;
        end else if (dead && (dead_count_q != 32'hFFFF_FFFF)) begin
            dead_count_q <= dead_count_q + 32'd1;
        end
    end

    assign dead_count_o = dead_count_q;
`else
    assign dead_count_o = '0;
`endif

    assign event_o          = event_q;
    assign event_type_o     = event_type_q;
    assign event_buf_o      = event_buf_q;
    assign event_done_o     = event_done_q;
    assign event_done_buf_o = event_done_buf_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign free_count_o     = free_count_q;
    assign dead_trig_o      = dead_q;

endmodule

// File: tb/tb_radiant_trig_sched.sv
// -----------------------------------------------------------------------------
// tb_radiant_trig_sched
//
// Directed scenarios with literal expectations, followed by randomized traffic.
// A timestamp-based reference model checks every cycle: a buffer pool array
// plus a "becomes idle at cycle N" value, instead of an explicit state machine.
// -----------------------------------------------------------------------------
module tb_radiant_trig_sched;

    localparam int NB = 4;
    localparam int BB = 2;
`ifdef RADIANT_TRIG_DEADCOUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run_en = 1'b0;
    logic          trig = 1'b0;
    logic          trig_type = 1'b0;
    logic [15:0]   holdoff = 16'd0;
    logic          dig_done = 1'b0;
    logic          rel = 1'b0;
    logic [BB-1:0] rel_buf = '0;

    logic          event_w;
    logic          event_type_w;
    logic [BB-1:0] event_buf_w;
    logic          event_done_w;
    logic [BB-1:0] event_done_buf_w;
    logic          busy_w;
    logic [BB:0]   free_count_w;
    logic          dead_w;
    logic [31:0]   dead_count_w;

    radiant_trig_sched #(.NUM_BUFS(NB), .BUF_BITS(BB)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .run_en_i         (run_en),
        .trig_i           (trig),
        .trig_type_i      (trig_type),
        .holdoff_i        (holdoff),
        .event_o          (event_w),
        .event_type_o     (event_type_w),
        .event_buf_o      (event_buf_w),
        .dig_done_i       (dig_done),
        .event_done_o     (event_done_w),
        .event_done_buf_o (event_done_buf_w),
        .release_i        (rel),
        .release_buf_i    (rel_buf),
        .busy_o           (busy_w),
        .free_count_o     (free_count_w),
        .dead_trig_o      (dead_w),
        .dead_count_o     (dead_count_w)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit      model_valid = 1'b0;
    bit      m_free[NB];
    int      m_ptr;
    bit      m_dig;
    int      m_cur;
    longint  m_ready;
    longint  cyc = 0;
    bit      e_event, e_type, e_done, e_dead, e_busy;
    int      e_buf, e_done_buf, e_free;
    longint  e_dcount;

    task automatic model_step();
        bit req, idle_now, rel_ok, acc;
        int idx, cnt;
        if (rst) begin
            foreach (m_free[i]) m_free[i] = 1'b1;
            m_ptr = 0; m_dig = 1'b0; m_cur = 0; m_ready = 0;
            e_event = 0; e_type = 0; e_buf = 0; e_done = 0; e_done_buf = 0;
            e_dead = 0; e_busy = 0; e_free = NB; e_dcount = 0;
            cyc = 0;
            model_valid = 1'b1;
            return;
        end
        req      = trig && run_en;
        idle_now = !m_dig && (cyc >= m_ready);
        rel_ok   = rel && !m_free[int'(rel_buf)] && !(m_dig && int'(rel_buf) == m_cur);
        idx = -1;
        for (int k = 0; k < NB; k++) begin
            if (idx < 0 && m_free[(m_ptr + k) % NB]) idx = (m_ptr + k) % NB;
        end
        acc = req && idle_now && (idx >= 0);
        e_event = 0; e_done = 0;
        e_dead  = req && !acc;
        if (e_dead && e_dcount != 64'h0000_0000_FFFF_FFFF) e_dcount++;
        if (acc) begin
            m_free[idx] = 1'b0;
            m_ptr   = (idx + 1) % NB;
            m_dig   = 1'b1;
            m_cur   = idx;
            e_event = 1; e_buf = idx; e_type = trig_type;
        end else if (m_dig && dig_done) begin
            m_dig      = 1'b0;
            m_ready    = cyc + 1 + longint'(holdoff);
            e_done     = 1;
            e_done_buf = m_cur;
        end
        if (rel_ok) m_free[int'(rel_buf)] = 1'b1;
        cyc++;
        e_busy = m_dig || (cyc < m_ready);
        cnt = 0;
        foreach (m_free[i]) cnt += int'(m_free[i]);
        e_free = cnt;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("m_event", event_w, e_event);
                if (e_event) chk("m_event_type", event_type_w, e_type);
                chk("m_event_buf", event_buf_w, e_buf);
                chk("m_event_done", event_done_w, e_done);
                if (e_done) chk("m_done_buf", event_done_buf_w, e_done_buf);
                chk("m_busy", busy_w, e_busy);
                chk("m_free_count", free_count_w, e_free);
                chk("m_dead", dead_w, e_dead);
                chk("m_dead_count", dead_count_w, DC_EN ? e_dcount : 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_free", free_count_w, 3'd4);
        chk("rst_busy", busy_w, 1'b0);
        chk("rst_event", event_w, 1'b0);
        chk("rst_buf", event_buf_w, 2'd0);
        chk("rst_dcount", dead_count_w, 32'd0);

        // 1: first trigger
        run_en = 1; trig = 1; trig_type = 1; step(); trig = 0; trig_type = 0;
        chk("t1_event", event_w, 1'b1);
        chk("t1_buf", event_buf_w, 2'd0);
        chk("t1_type", event_type_w, 1'b1);
        chk("t1_busy", busy_w, 1'b1);
        chk("t1_free", free_count_w, 3'd3);
        $display("[TB] txn trigger -> buf %0d type %0d", event_buf_w, event_type_w);

        // 2: done with holdoff 5, trigger during holdoff
        holdoff = 16'd5; dig_done = 1; step(); dig_done = 0;
        chk("t2_done", event_done_w, 1'b1);
        chk("t2_done_buf", event_done_buf_w, 2'd0);
        chk("t2_busy0", busy_w, 1'b1);
        trig = 1; step(); trig = 0;
        chk("t2_dead", dead_w, 1'b1);
        chk("t2_dcount", dead_count_w, DC_EN ? 32'd1 : 32'd0);
        step(); step(); step();
        chk("t2_busy4", busy_w, 1'b1);
        step();
        chk("t2_idle", busy_w, 1'b0);
        $display("[TB] txn holdoff 5 complete");

        // 3: fill all buffers, then dead / release races
        do_reset();
        holdoff = 16'd0;
        for (int k = 0; k < NB; k++) begin
            trig = 1; trig_type = k[0]; step(); trig = 0;
            chk("t3_event", event_w, 1'b1);
            chk("t3_buf", event_buf_w, k);
            dig_done = 1; step(); dig_done = 0;
            chk("t3_done_buf", event_done_buf_w, k);
            $display("[TB] txn fill -> buf %0d", event_buf_w);
        end
        chk("t3_free0", free_count_w, 3'd0);
        trig = 1; step();
        chk("t3_dead_full", dead_w, 1'b1);
        chk("t3_no_event", event_w, 1'b0);
        rel = 1; rel_buf = 2'd2; step(); rel = 0;
        chk("t3_dead_race", dead_w, 1'b1);
        chk("t3_free1", free_count_w, 3'd1);
        step(); trig = 0;
        chk("t3_event2", event_w, 1'b1);
        chk("t3_buf2", event_buf_w, 2'd2);
        dig_done = 1; step(); dig_done = 0;

        // 4: wrap-around allocation
        rel = 1; rel_buf = 2'd1; step(); rel_buf = 2'd3; step(); rel = 0;
        chk("t4_free2", free_count_w, 3'd2);
        trig = 1; step(); trig = 0;
        chk("t4_buf3", event_buf_w, 2'd3);
        dig_done = 1; step(); dig_done = 0;
        trig = 1; step(); trig = 0;
        chk("t4_buf1", event_buf_w, 2'd1);
        dig_done = 1; step(); dig_done = 0;
        $display("[TB] txn wrap -> buf %0d", event_buf_w);

        // 5: reset mid-DIGITIZE, then a late dig_done
        rel = 1; rel_buf = 2'd0; step(); rel = 0;
        trig = 1; step(); trig = 0;
        chk("t5_busy", busy_w, 1'b1);
        rst = 1; step(); rst = 0;
        dig_done = 1; step(); dig_done = 0;
        chk("t5_no_done", event_done_w, 1'b0);
        chk("t5_free", free_count_w, 3'd4);
        chk("t5_dcount", dead_count_w, 32'd0);
        chk("t5_idle", busy_w, 1'b0);

        // 6: run disabled, redundant release
        run_en = 0;
        for (int k = 0; k < 3; k++) begin
            trig = 1; step(); trig = 0; step();
            chk("t6_no_event", event_w, 1'b0);
            chk("t6_no_dead", dead_w, 1'b0);
        end
        rel = 1; rel_buf = 2'd1; step(); rel = 0;
        chk("t6_free", free_count_w, 3'd4);
        run_en = 1;

        // randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            run_en    = ($urandom_range(0, 9) != 0);
            trig      = ($urandom_range(0, 9) < 3);
            trig_type = 1'($urandom_range(0, 1));
            dig_done  = ($urandom_range(0, 3) == 0);
            holdoff   = 16'($urandom_range(0, 6));
            rel       = ($urandom_range(0, 4) == 0);
            rel_buf   = BB'($urandom_range(0, NB - 1));
            step();
        end
        rst = 0; trig = 0; dig_done = 0; rel = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
